// File: rtl/vram_fill_wb_if.sv
// Wishbone classic bus bundle for the video RAM CPU port.
// master: drives address/data/control, receives read data and acknowledge.
// slave : receives address/data/control, returns read data and acknowledge.
interface vram_fill_wb_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0] wb_adr_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_we_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic              wb_stb_i;
    logic              wb_cyc_i;
    logic              wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/vram_fill_wb.sv
// Dual-port video RAM with a constant-fill engine.
// Ports:
//   wb_clk_i / wb_rst_i : clock, asynchronous active-high reset
//   wb                  : Wishbone classic slave (byte-masked write, read-before-write)
//   gb_adr_i / gb_dat_o : graphics read port, 1-cycle latency
//   fill_*              : fill engine start/abort controls and busy/done status
module vram_fill_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DEPTH  = 24576
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    vram_fill_wb_if.slave      wb,
    input  logic [ADDR_W-1:0]  gb_adr_i,
    output logic [DATA_W-1:0]  gb_dat_o,
    input  logic               fill_start_i,
    input  logic [ADDR_W-1:0]  fill_base_i,
    input  logic [ADDR_W:0]    fill_len_i,
    input  logic [DATA_W-1:0]  fill_val_i,
    input  logic               fill_abort_i,
    output logic               fill_busy_o,
    output logic               fill_done_o
);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              ack_q, busy_q, done_q;
    logic              busy_d, done_d;
    logic [DATA_W-1:0] wb_dat_q, gb_dat_q;

    logic              wb_acc_c, wb_in_rng_c, gb_in_rng_c, fill_we_c;
    logic [DATA_W-1:0] wb_old_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_adr_c;
    logic [DATA_W-1:0] mem_dat_c;

    assign wb_acc_c    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wb_in_rng_c = {1'b0, wb.wb_adr_i} < DEPTH_W;
    assign gb_in_rng_c = {1'b0, gb_adr_i} < DEPTH_W;
    assign wb_old_c    = wb_in_rng_c ? mem[wb.wb_adr_i] : '0;

    // Fill FSM: Wishbone acceptance stalls the fill, so the two never write together.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        val_d     = val_q;
        fill_we_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_start_i) begin
                    if (fill_len_i == '0 || {1'b0, fill_base_i} >= DEPTH_W) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        ptr_d   = fill_base_i;
                        cnt_d   = fill_len_i;
                        val_d   = fill_val_i;
                    end
                end
            end
            S_RUN: begin
                if (fill_abort_i) begin
                    state_d = S_DONE;
                end else if (!wb_acc_c) begin
                    fill_we_c = 1'b1;
                    if (cnt_q == (ADDR_W+1)'(1) || ptr_q == LAST_ADR) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        cnt_d = cnt_q - (ADDR_W+1)'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Single write port: byte-merged Wishbone word, else the fill word.
    always_comb begin
        mem_we_c  = 1'b0;
        mem_adr_c = ptr_q;
        mem_dat_c = val_q;
        if (wb_acc_c && wb.wb_we_i && wb_in_rng_c) begin
            mem_we_c  = 1'b1;
            mem_adr_c = wb.wb_adr_i;
            for (int unsigned b = 0; b < SEL_W; b++) begin
                mem_dat_c[b*8 +: 8] = wb.wb_sel_i[b] ? wb.wb_dat_i[b*8 +: 8] : wb_old_c[b*8 +: 8];
            end
        end else if (fill_we_c) begin
            mem_we_c = 1'b1;
        end
    end

    // RAM array (not reset).
    always_ff @(posedge wb_clk_i) begin
        if (mem_we_c) begin
            mem[mem_adr_c] <= mem_dat_c;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            val_q    <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wb_dat_q <= '0;
            gb_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            ack_q    <= wb_acc_c;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gb_dat_q <= gb_in_rng_c ? mem[gb_adr_i] : '0;
            if (wb_acc_c) begin
                wb_dat_q <= wb_old_c;
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = wb_dat_q;
    assign gb_dat_o    = gb_dat_q;
    assign fill_busy_o = busy_q;
    assign fill_done_o = done_q;
endmodule

// File: tb/tb_vram_fill_wb.sv
// Directed bench for vram_fill_wb: Wishbone vector table plus fill-engine sequences.
module tb_vram_fill_wb;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DEPTH  = 24576;
    localparam logic [ADDR_W-1:0] DEP_A = ADDR_W'(DEPTH);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vram_fill_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wbif ();

    logic [ADDR_W-1:0] gb_adr;
    logic [DATA_W-1:0] gb_dat;
    logic              fill_start, fill_abort, fill_busy, fill_done;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_len;
    logic [DATA_W-1:0] fill_val;

    vram_fill_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wb           (wbif),
        .gb_adr_i     (gb_adr),
        .gb_dat_o     (gb_dat),
        .fill_start_i (fill_start),
        .fill_base_i  (fill_base),
        .fill_len_i   (fill_len),
        .fill_val_i   (fill_val),
        .fill_abort_i (fill_abort),
        .fill_busy_o  (fill_busy),
        .fill_done_o  (fill_done)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [31:0]       dat;
        logic [3:0]        sel;
        logic              chk;
        logic [31:0]       exp;
    } wb_vec_t;

    wb_vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after an edge.
    task automatic wb_xfer(input logic we, input logic [ADDR_W-1:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        wbif.wb_cyc_i = 1'b1;
        wbif.wb_stb_i = 1'b1;
        wbif.wb_we_i  = we;
        wbif.wb_adr_i = adr;
        wbif.wb_dat_i = dat;
        wbif.wb_sel_i = sel;
        @(posedge clk); #1;
        check("wb_ack_high", 32'(wbif.wb_ack_o), 32'd1);
        rd = wbif.wb_dat_o;
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        wbif.wb_we_i  = 1'b0;
        @(posedge clk); #1;
        check("wb_ack_single", 32'(wbif.wb_ack_o), 32'd0);
    endtask

    task automatic gb_check(input string name, input logic [ADDR_W-1:0] adr, input logic [31:0] exp);
        gb_adr = adr;
        @(posedge clk); #1;
        check(name, gb_dat, exp);
    endtask

    // c counts edges after the start is driven; edge c=1 samples the start.
    task automatic fill_run(input string tag, input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                            input logic [31:0] val, input int wb_at, input logic [ADDR_W-1:0] wadr,
                            input logic [31:0] wdat, input int abort_at, input int exp_cycles);
        int busy_cycles, done_cycle, pulses;
        busy_cycles = 0; done_cycle = 0; pulses = 0;
        fill_start = 1'b1;
        fill_base  = base;
        fill_len   = len;
        fill_val   = val;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 1) fill_start = 1'b0;
            if (fill_busy) busy_cycles++;
            if (fill_done) begin pulses++; done_cycle = c; end
            if (c == wb_at + 1 && wb_at != 0) begin
                check({tag, "_wb_ack"}, 32'(wbif.wb_ack_o), 32'd1);
                wbif.wb_cyc_i = 1'b0;
                wbif.wb_stb_i = 1'b0;
                wbif.wb_we_i  = 1'b0;
            end
            if (c == wb_at && wb_at != 0) begin
                wbif.wb_cyc_i = 1'b1;
                wbif.wb_stb_i = 1'b1;
                wbif.wb_we_i  = 1'b1;
                wbif.wb_adr_i = wadr;
                wbif.wb_dat_i = wdat;
                wbif.wb_sel_i = 4'hF;
            end
            if (c == abort_at + 1) fill_abort = 1'b0;
            if (c == abort_at && abort_at != 0) fill_abort = 1'b1;
            if (!fill_busy) break;
        end
        check({tag, "_idle_at_end"}, 32'(fill_busy), 32'd0);
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_cycles));
        check({tag, "_done_cycle"}, 32'(done_cycle), 32'(exp_cycles));
        check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int pulses;

        vecs[0] = '{1'b1, 15'h010, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 15'h010, 32'h0000AA00, 4'b0010, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 15'h010, 32'h0,        4'b0000, 1'b1, 32'hDEADAAEF};
        vecs[3] = '{1'b1, 15'h000, 32'h11223344, 4'b1111, 1'b0, 32'h0};
        vecs[4] = '{1'b0, DEP_A,   32'h0,        4'b0000, 1'b1, 32'h0};
        vecs[5] = '{1'b1, DEP_A,   32'h55555555, 4'b1111, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 15'h000, 32'h0,        4'b0000, 1'b1, 32'h11223344};
        vecs[7] = '{1'b1, 15'h020, 32'h00000000, 4'b1111, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 15'h020, 32'hA5A5A5A5, 4'b1001, 1'b1, 32'h00000000};
        vecs[9] = '{1'b0, 15'h020, 32'h0,        4'b0000, 1'b1, 32'hA50000A5};

        rst = 1'b1;
        wbif.wb_cyc_i = 1'b0; wbif.wb_stb_i = 1'b0; wbif.wb_we_i = 1'b0;
        wbif.wb_adr_i = '0;   wbif.wb_dat_i = '0;   wbif.wb_sel_i = '0;
        gb_adr = '0; fill_start = 1'b0; fill_abort = 1'b0;
        fill_base = '0; fill_len = '0; fill_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(wbif.wb_ack_o), 32'd0);
        check("rst_wb_dat", wbif.wb_dat_o, 32'd0);
        check("rst_gb_dat", gb_dat, 32'd0);
        check("rst_busy", 32'(fill_busy), 32'd0);
        check("rst_done", 32'(fill_done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
            if (vecs[i].chk) check($sformatf("wb_vec%0d", i), rd, vecs[i].exp);
        end
        gb_check("gb_0x10", 15'h010, 32'hDEADAAEF);
        gb_check("gb_depth", DEP_A, 32'h0);

        // Basic fill with fenced neighbours.
        wb_xfer(1'b1, 15'h0FF, 32'hFFFF0000, 4'hF, rd);
        wb_xfer(1'b1, 15'h104, 32'h10410410, 4'hF, rd);
        fill_run("fill4", 15'h100, 16'd4, 32'h12345678, 0, '0, '0, 0, 5);
        for (int a = 'h100; a < 'h104; a++) gb_check($sformatf("fill4_%0h", a), ADDR_W'(a), 32'h12345678);
        gb_check("fill4_below", 15'h0FF, 32'hFFFF0000);
        gb_check("fill4_above", 15'h104, 32'h10410410);

        // Wishbone write lands right after the fill wrote 0x210; fill stalls one cycle.
        wb_xfer(1'b1, 15'h240, 32'h24024024, 4'hF, rd);
        fill_run("fill64", 15'h200, 16'd64, 32'h77777777, 18, 15'h210, 32'hCAFEF00D, 0, 66);
        gb_check("fill64_wb_word", 15'h210, 32'hCAFEF00D);
        gb_check("fill64_20f", 15'h20F, 32'h77777777);
        gb_check("fill64_211", 15'h211, 32'h77777777);
        gb_check("fill64_last", 15'h23F, 32'h77777777);
        gb_check("fill64_above", 15'h240, 32'h24024024);

        // Clip at end of memory.
        wb_xfer(1'b1, DEP_A - 15'd3, 32'h33333333, 4'hF, rd);
        fill_run("clip", DEP_A - 15'd2, 16'd8, 32'h5A5A5A5A, 0, '0, '0, 0, 3);
        gb_check("clip_m3", DEP_A - 15'd3, 32'h33333333);
        gb_check("clip_m2", DEP_A - 15'd2, 32'h5A5A5A5A);
        gb_check("clip_m1", DEP_A - 15'd1, 32'h5A5A5A5A);
        gb_check("clip_nowrap", 15'h000, 32'h11223344);

        // Zero length and out-of-range base.
        wb_xfer(1'b1, 15'h400, 32'h44444444, 4'hF, rd);
        fill_run("len0", 15'h400, 16'd0, 32'hEEEEEEEE, 0, '0, '0, 0, 1);
        gb_check("len0_nowrite", 15'h400, 32'h44444444);
        fill_run("base_oob", DEP_A, 16'd4, 32'hEEEEEEEE, 0, '0, '0, 0, 1);
        gb_check("base_oob_nowrite", 15'h000, 32'h11223344);

        // Abort after three words.
        fill_run("clear300", 15'h300, 16'd16, 32'h0, 0, '0, '0, 0, 17);
        fill_run("abort", 15'h300, 16'd10, 32'hABABABAB, 0, '0, '0, 4, 5);
        gb_check("abort_w2", 15'h302, 32'hABABABAB);
        gb_check("abort_w3", 15'h303, 32'h0);

        // Reset in the middle of a fill.
        fill_run("clear500", 15'h500, 16'd32, 32'h0, 0, '0, '0, 0, 33);
        fill_start = 1'b1; fill_base = 15'h500; fill_len = 16'd20; fill_val = 32'h99999999;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) fill_start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rstmid_busy", 32'(fill_busy), 32'd0);
        check("rstmid_wb_dat", wbif.wb_dat_o, 32'd0);
        pulses = 0;
        @(posedge clk); #1;
        if (fill_done) pulses++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (fill_done) pulses++;
        end
        check("rstmid_no_done", 32'(pulses), 32'd0);
        check("rstmid_idle", 32'(fill_busy), 32'd0);
        gb_check("rstmid_kept", 15'h503, 32'h99999999);
        gb_check("rstmid_stopped", 15'h504, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
